shift_sequencer: RTL

Multi-cycle controller that sequences the shared 8-bit gate-level left shifter (3-bit amount, 0–7) to perform full-range shift and rotate operations. It accepts shift requests with an 8-bit amount and decomposes each into passes of at most 7 bits. It drives the shifter's amount/data inputs and captures its output each clock. It sits between the ALU control path and the shifter instance, and turns one combinational left shifter into SLL, SRL and (optionally) ROL units.

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Bus bundle for shift_sequencer: ALU-side request/result signals plus the
// amount/data/result path to the shared 8-bit combinational left shifter.
interface shift_sequencer_if;
  logic       START;
  logic [1:0] OP;
  logic [7:0] DATA;
  logic [7:0] AMOUNT;
  logic [2:0] SH_S;
  logic [7:0] SH_DATA;
  logic [7:0] SH_OUT;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;

  // Request side (ALU control path) and shifter instance.
  modport master (
    output START, OP, DATA, AMOUNT, SH_OUT,
    input  SH_S, SH_DATA, BUSY, DONE, RESULT
  );

  // The sequencer itself.
  modport slave (
    input  START, OP, DATA, AMOUNT, SH_OUT,
    output SH_S, SH_DATA, BUSY, DONE, RESULT
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/ROL controller around a shared 8-bit, 0-7 left shifter.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer (
  input  logic               CLK,
  input  logic               RESET,
  shift_sequencer_if.slave   bus,
  output logic [1:0]         dbg_state
);

  // Handshake: START is sampled only in IDLE; BUSY is high while a request is
  // in flight (SHIFT and DONE); DONE pulses for one cycle with RESULT valid,
  // and RESULT then holds until the next completion.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [1:0] OP_ROL = 2'b10;
`endif

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] work_q, work_d;
  logic [3:0] remain_q, remain_d;
  logic [7:0] result_q, result_d;
  logic [3:0] eff_amt;
  logic [2:0] step;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_comb begin
    eff_amt = 4'd0;
    case (bus.OP)
      OP_SLL, OP_SRL: eff_amt = (bus.AMOUNT >= 8'd8) ? 4'd8 : bus.AMOUNT[3:0];
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROL:         eff_amt = {1'b0, bus.AMOUNT[2:0]};
`endif
      default:        eff_amt = 4'd0;
    endcase
  end

  assign step = (remain_q > 4'd7) ? 3'd7 : remain_q[2:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    remain_d = remain_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          op_d     = bus.OP;
          // SRL runs on the left shifter by reversing bits on the way in and out.
          work_d   = (bus.OP == OP_SRL) ? rev8(bus.DATA) : bus.DATA;
          remain_d = eff_amt;
          state_d  = (eff_amt != 4'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        work_d = bus.SH_OUT;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (op_q == OP_ROL)
          work_d = bus.SH_OUT | (work_q >> (4'd8 - {1'b0, step}));
`endif
        remain_d = remain_q - {1'b0, step};
        if (remain_d == 4'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE)
      result_d = (op_d == OP_SRL) ? rev8(work_d) : work_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      work_q   <= 8'h00;
      remain_q <= 4'd0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      remain_q <= remain_d;
      result_q <= result_d;
    end
  end

  assign bus.SH_S    = (state_q == S_SHIFT) ? step : 3'd0;
  assign bus.SH_DATA = work_q;
  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.DONE    = (state_q == S_DONE);
  assign bus.RESULT  = result_q;
  assign dbg_state   = state_q;

endmodule
